// File: rtl/mmio_req_buffer.sv
// mmio_req_buffer: in-order MMIO request FIFO with read throttling, in-order read return and debug counters/flags.
module mmio_req_buffer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int MAX_RD     = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] h_address,
    input  logic                  h_read,
    input  logic                  h_write,
    input  logic [63:0]           h_writedata,
    input  logic [7:0]            h_byteenable,
    output logic                  h_waitrequest,
    output logic [63:0]           h_readdata,
    output logic                  h_readdatavalid,
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [63:0]           s_writedata,
    output logic [7:0]            s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [63:0]           s_readdata,
    input  logic                  s_readdatavalid,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic                  err_both,
    output logic                  err_unsolicited
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0]      m_w;
    logic [ADDR_WIDTH-1:0] m_a  [DEPTH];
    logic [63:0]           m_d  [DEPTH];
    logic [7:0]            m_be [DEPTH];
    logic [PW-1:0]         wp, rp;
    logic [PW:0]           cnt;
    logic [3:0]            rd_out;
    logic [ADDR_WIDTH-1:0] last_a;
    logic [63:0]           last_d;
    logic [7:0]            last_be;
    logic                  nonempty, accept, pop, rsp_ok;

    assign nonempty      = cnt != '0;
    assign h_waitrequest = cnt == (PW+1)'(DEPTH);
    assign accept        = (h_read | h_write) && !h_waitrequest;
    assign s_read        = nonempty && !m_w[rp] && rd_out != 4'(MAX_RD);
    assign s_write       = nonempty && m_w[rp];
    // with the FIFO empty the slave side keeps showing the last issued request
    assign s_address     = nonempty ? m_a[rp]  : last_a;
    assign s_writedata   = nonempty ? m_d[rp]  : last_d;
    assign s_byteenable  = nonempty ? m_be[rp] : last_be;
    assign pop           = (s_read | s_write) && !s_waitrequest;
    assign rsp_ok        = s_readdatavalid && rd_out != '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            m_w[wp]  <= h_write;
            m_a[wp]  <= h_address;
            m_d[wp]  <= h_writedata;
            m_be[wp] <= h_byteenable;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp              <= '0;
            rp              <= '0;
            cnt             <= '0;
            rd_out          <= '0;
            last_a          <= '0;
            last_d          <= '0;
            last_be         <= '0;
            rd_count        <= '0;
            wr_count        <= '0;
            err_both        <= 1'b0;
            err_unsolicited <= 1'b0;
            h_readdatavalid <= 1'b0;
            h_readdata      <= '0;
        end else begin
            if (accept) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            cnt    <= cnt + (PW+1)'(accept) - (PW+1)'(pop);
            rd_out <= rd_out + 4'(pop && s_read) - 4'(rsp_ok);
            if (pop) begin
                last_a  <= m_a[rp];
                last_d  <= m_d[rp];
                last_be <= m_be[rp];
            end
            if (pop && s_read) rd_count <= rd_count + 16'd1;
            if (pop && s_write) wr_count <= wr_count + 16'd1;
            if (accept && h_read && h_write) err_both <= 1'b1;
            if (s_readdatavalid && rd_out == '0) err_unsolicited <= 1'b1;
            h_readdatavalid <= rsp_ok;
            if (rsp_ok) h_readdata <= s_readdata;
        end
    end
endmodule

// File: tb/tb_mmio_req_buffer.sv
// tb_mmio_req_buffer: directed vectors, corner sequences and a queue-based random reference for mmio_req_buffer.
module tb_mmio_req_buffer;
    logic        clk = 0, reset_n = 0;
    logic [15:0] h_address = 0, s_address;
    logic        h_read = 0, h_write = 0, h_waitrequest, h_readdatavalid;
    logic [63:0] h_writedata = 0, h_readdata, s_writedata, s_readdata = 0;
    logic [7:0]  h_byteenable = 0, s_byteenable;
    logic        s_read, s_write, s_waitrequest = 0, s_readdatavalid = 0;
    logic [15:0] rd_count, wr_count;
    logic        err_both, err_unsolicited;
    int          checks = 0, errors = 0;

    mmio_req_buffer dut (
        .clk(clk), .reset_n(reset_n), .h_address(h_address), .h_read(h_read), .h_write(h_write),
        .h_writedata(h_writedata), .h_byteenable(h_byteenable), .h_waitrequest(h_waitrequest),
        .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid), .s_address(s_address),
        .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .rd_count(rd_count), .wr_count(wr_count), .err_both(err_both), .err_unsolicited(err_unsolicited)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hr, hw;
        logic [15:0] addr;
        logic [63:0] wd;
        logic [7:0]  be;
        logic        srv;
        logic [63:0] srd;
        logic        sr, sw;
        logic [15:0] saddr;
        logic [63:0] swd;
        logic [7:0]  sbe;
        logic        hwait, hrdv;
        logic [63:0] hrd;
        logic [15:0] rdc, wrc;
        logic        eb, eu;
    } vec_t;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [63:0] d;
        logic [7:0]  be;
    } ent_t;

    vec_t tv [11];
    ent_t q[$];
    ent_t last, hd;
    int   m_out, m_rdc, m_wrc, o0, pops;
    logic m_hrdv, m_eb, m_eu, e_sr, e_sw, p, acc;
    logic [63:0] m_hrd;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    task automatic idle();
        h_read = 0; h_write = 0; h_address = 0; h_writedata = 0; h_byteenable = 0;
        s_waitrequest = 0; s_readdatavalid = 0; s_readdata = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        q.delete();
        last = '{0, 0, 0, 0};
        m_out = 0; m_rdc = 0; m_wrc = 0; m_hrdv = 0; m_hrd = 0; m_eb = 0; m_eu = 0;
    endtask

    initial begin
        // hr hw addr wd be srv srd | sr sw saddr swd sbe hwait hrdv hrd rdc wrc eb eu
        tv[0]  = '{0, 1, 'h20, 'hDEADBEEF, 'hFF, 0, 0,      0, 0, 0,    0,          0,    0, 0, 0,      0, 0, 0, 0};
        tv[1]  = '{0, 0, 0,    0,          0,    0, 0,      0, 1, 'h20, 'hDEADBEEF, 'hFF, 0, 0, 0,      0, 0, 0, 0};
        tv[2]  = '{0, 0, 0,    0,          0,    0, 0,      0, 0, 'h20, 'hDEADBEEF, 'hFF, 0, 0, 0,      0, 1, 0, 0};
        tv[3]  = '{1, 1, 1,    5,          'h0F, 0, 0,      0, 0, 'h20, 'hDEADBEEF, 'hFF, 0, 0, 0,      0, 1, 0, 0};
        tv[4]  = '{0, 0, 0,    0,          0,    0, 0,      0, 1, 1,    5,          'h0F, 0, 0, 0,      0, 1, 1, 0};
        tv[5]  = '{0, 0, 0,    0,          0,    0, 0,      0, 0, 1,    5,          'h0F, 0, 0, 0,      0, 2, 1, 0};
        tv[6]  = '{1, 0, 'h40, 0,          0,    0, 0,      0, 0, 1,    5,          'h0F, 0, 0, 0,      0, 2, 1, 0};
        tv[7]  = '{0, 0, 0,    0,          0,    0, 0,      1, 0, 'h40, 0,          0,    0, 0, 0,      0, 2, 1, 0};
        tv[8]  = '{0, 0, 0,    0,          0,    1, 'h1234, 0, 0, 'h40, 0,          0,    0, 0, 0,      1, 2, 1, 0};
        tv[9]  = '{0, 0, 0,    0,          0,    1, 'h5555, 0, 0, 'h40, 0,          0,    0, 1, 'h1234, 1, 2, 1, 0};
        tv[10] = '{0, 0, 0,    0,          0,    0, 0,      0, 0, 'h40, 0,          0,    0, 0, 'h1234, 1, 2, 1, 1};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            h_read = tv[i].hr; h_write = tv[i].hw; h_address = tv[i].addr; h_writedata = tv[i].wd;
            h_byteenable = tv[i].be; s_readdatavalid = tv[i].srv; s_readdata = tv[i].srd;
            #4;
            chk($sformatf("v%0d s_read", i), s_read, tv[i].sr);
            chk($sformatf("v%0d s_write", i), s_write, tv[i].sw);
            chk($sformatf("v%0d s_address", i), s_address, tv[i].saddr);
            chk($sformatf("v%0d s_writedata", i), s_writedata, tv[i].swd);
            chk($sformatf("v%0d s_byteenable", i), s_byteenable, tv[i].sbe);
            chk($sformatf("v%0d h_waitrequest", i), h_waitrequest, tv[i].hwait);
            chk($sformatf("v%0d h_readdatavalid", i), h_readdatavalid, tv[i].hrdv);
            chk($sformatf("v%0d h_readdata", i), h_readdata, tv[i].hrd);
            chk($sformatf("v%0d rd_count", i), rd_count, tv[i].rdc);
            chk($sformatf("v%0d wr_count", i), wr_count, tv[i].wrc);
            chk($sformatf("v%0d err_both", i), err_both, tv[i].eb);
            chk($sformatf("v%0d err_unsolicited", i), err_unsolicited, tv[i].eu);
            @(posedge clk); #1;
        end

        // five writes into a stalled slave, then drain in order
        do_reset();
        s_waitrequest = 1;
        for (int i = 0; i < 5; i++) begin
            h_write = 1; h_address = 16'h100 + 16'(i); h_writedata = 64'(i);
            #4 chk($sformatf("fill%0d h_waitrequest", i), h_waitrequest, i == 4);
            @(posedge clk); #1;
        end
        s_waitrequest = 0;
        for (int k = 0; k < 5; k++) begin
            #4;
            chk($sformatf("drain%0d s_write", k), s_write, 1);
            chk($sformatf("drain%0d s_address", k), s_address, 16'h100 + 16'(k));
            if (k == 0) chk("drain0 h_waitrequest", h_waitrequest, 1);
            @(posedge clk); #1;
            if (k == 1) h_write = 0;
        end
        chk("drain wr_count", wr_count, 5);

        // read throttle at MAX_RD outstanding
        do_reset();
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            h_read = i < 6; h_address = 16'h200 + 16'(i);
            #4 if (s_read && !s_waitrequest) pops++;
            @(posedge clk); #1;
        end
        h_read = 0;
        #4;
        chk("throttle pops", 64'(pops), 4);
        chk("throttle s_read", s_read, 0);
        chk("throttle rd_count", rd_count, 4);
        @(posedge clk); #1;
        s_readdatavalid = 1; s_readdata = 64'h1234;
        @(posedge clk); #1;
        s_readdatavalid = 0;
        #4;
        chk("throttle h_readdatavalid", h_readdatavalid, 1);
        chk("throttle h_readdata", h_readdata, 64'h1234);
        chk("throttle s_read resumes", s_read, 1);
        chk("throttle s_address", s_address, 16'h204);

        // asynchronous reset with queued entries
        do_reset();
        s_waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            h_write = 1; h_read = i == 1; h_address = 16'h300 + 16'(i); h_writedata = 64'hABCD;
            @(posedge clk); #1;
        end
        h_write = 0; h_read = 0;
        #2;
        chk("prerst s_write", s_write, 1);
        chk("prerst err_both", err_both, 1);
        reset_n = 0;
        #1;
        chk("rst s_write", s_write, 0);
        chk("rst s_address", s_address, 0);
        chk("rst s_writedata", s_writedata, 0);
        chk("rst err_both", err_both, 0);
        chk("rst h_waitrequest", h_waitrequest, 0);
        @(posedge clk); #1 reset_n = 1;
        s_waitrequest = 0;
        for (int i = 0; i < 3; i++) begin
            #4 chk($sformatf("postrst%0d strobes", i), {s_read, s_write}, 0);
            @(posedge clk); #1;
        end

        // random traffic against a queue-level reference
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            chk("rnd rd_count", rd_count, 16'(m_rdc));
            chk("rnd wr_count", wr_count, 16'(m_wrc));
            chk("rnd h_readdatavalid", h_readdatavalid, m_hrdv);
            chk("rnd h_readdata", h_readdata, m_hrd);
            chk("rnd err_both", err_both, m_eb);
            chk("rnd err_unsolicited", err_unsolicited, m_eu);
            h_read = $urandom % 3 == 0; h_write = $urandom % 3 == 0;
            h_address = 16'($urandom); h_writedata = {$urandom, $urandom}; h_byteenable = 8'($urandom);
            s_waitrequest = $urandom % 4 == 0;
            s_readdatavalid = m_out > 0 && $urandom % 3 == 0;
            s_readdata = {$urandom, $urandom};
            #4;
            hd = q.size() > 0 ? q[0] : last;
            e_sr = q.size() > 0 && !hd.w && m_out < 4;
            e_sw = q.size() > 0 && hd.w;
            chk("rnd h_waitrequest", h_waitrequest, q.size() == 4);
            chk("rnd s_read", s_read, e_sr);
            chk("rnd s_write", s_write, e_sw);
            chk("rnd s_address", s_address, hd.a);
            chk("rnd s_writedata", s_writedata, hd.d);
            chk("rnd s_byteenable", s_byteenable, hd.be);
            p = (e_sr || e_sw) && !s_waitrequest;
            acc = (h_read || h_write) && q.size() < 4;
            o0 = m_out;
            if (p) begin
                last = q.pop_front();
                if (e_sr) begin m_out++; m_rdc = (m_rdc + 1) % 65536; end
                else m_wrc = (m_wrc + 1) % 65536;
            end
            if (acc) q.push_back('{h_write, h_address, h_writedata, h_byteenable});
            if (acc && h_read && h_write) m_eb = 1;
            m_hrdv = 0;
            if (s_readdatavalid) begin
                if (o0 > 0) begin m_out--; m_hrdv = 1; m_hrd = s_readdata; end
                else m_eu = 1;
            end
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_req_buffer.md
# mmio_req_buffer

Request-side buffer between the platform 64-bit Avalon MMIO host port and the AFU CSR/BRAM slave. Accepts host reads and writes into a small in-order FIFO and re-issues them downstream one per cycle. Absorbs downstream waitrequest and caps outstanding reads. Returns read data to the host in order with one registered cycle, and keeps wrap-around read/write counters plus sticky protocol-error flags for debug CSRs.

## Interface
Parameters:
- ADDR_WIDTH, 16, MMIO word address width (host and slave sides)
- DEPTH, 4, request FIFO entries (power of two, ≥2)
- MAX_RD, 4, maximum reads issued downstream and not yet answered (1..15)

Ports:
- clk  in  1  single clock; all logic in this domain
- reset_n  in  1  reset, asynchronous, active-low
- h_address  in  ADDR_WIDTH  host word address
- h_read / h_write  in  1  host request strobes
- h_writedata  in  64  host write data
- h_byteenable  in  8  host byte enables
- h_waitrequest  out  1  backpressure to host
- h_readdata  out  64  read data to host
- h_readdatavalid  out  1  read data qualifier
- s_address  out  ADDR_WIDTH  slave address
- s_read / s_write  out  1  slave request strobes
- s_writedata  out  64; s_byteenable  out  8
- s_waitrequest  in  1  slave backpressure
- s_readdata  in  64; s_readdatavalid  in  1  slave read response
- rd_count / wr_count  out  16  requests issued downstream, wrap at 0xFFFF→0
- err_both  out  1  sticky: host asserted read and write together
- err_unsolicited  out  1  sticky: s_readdatavalid with zero reads outstanding

## Operation
- Entry = {is_write, address, writedata, byteenable}. Accept when (h_read|h_write) && !h_waitrequest; push at that edge.
- h_waitrequest = (fifo_count == DEPTH), combinational from registered count. No pass-through when full, even if a pop occurs that cycle.
- h_read && h_write together: stored as a write; err_both set.
- Downstream: when FIFO non-empty, head drives s_* (s_read = !is_write, s_write = is_write). When empty, s_read = s_write = 0; other s_* hold the last head value.
- Read throttle: head read is not presented (s_read = 0) while rd_outstanding == MAX_RD. Strict order: a throttled read also blocks writes behind it.
- Pop at edge where a strobe is presented and s_waitrequest = 0. rd_count/wr_count increment on that pop.
- rd_outstanding (4 bits): +1 on read pop, −1 on s_readdatavalid; both in one cycle → unchanged. s_readdatavalid at 0 → count stays 0, data dropped, err_unsolicited set.
- Push and pop in the same cycle: count unchanged, pointers both advance, wrap modulo DEPTH.
- Error flags clear only on reset.

## Timing
- Reset (async assert, sync release): FIFO empty, pointers/counters 0, rd_outstanding 0. All outputs 0 except h_waitrequest = 0. Mid-operation reset flushes queued requests; answers to in-flight reads are lost.
- Request accepted at edge N is visible on s_* from cycle N+1 (minimum latency 1).
- Throughput: 1 request/cycle each side when not stalled.
- s_readdatavalid at edge M → h_readdatavalid/h_readdata registered, valid for cycle M+1, exactly one cycle per response. h_readdata holds its last value otherwise.
- s_* are stable while s_waitrequest = 1 (head does not change until pop).

## Test plan
- Single write 0x0020 data 0xDEAD_BEEF, be 0xFF, s_waitrequest = 0 → s_write high for one cycle, the cycle after acceptance, same data; wr_count = 1.
- Five back-to-back host writes with s_waitrequest held 1, DEPTH = 4 → 4 accepted, h_waitrequest = 1 on 5th. Release → 4 issued in order on consecutive cycles, then 5th accepted.
- Six reads, slave never answers, MAX_RD = 4 → exactly 4 s_read pops, s_read = 0 afterwards. One s_readdatavalid (data 0x1234) → h_readdatavalid one cycle later with 0x1234; 5th read issues.
- Same-cycle read pop and s_readdatavalid at rd_outstanding = 2 → stays 2; s_readdatavalid with nothing outstanding → err_unsolicited = 1, no h_readdatavalid.
- h_read and h_write both high, address 0x0001 → one s_write issued, err_both = 1.
- Assert reset_n = 0 with 3 queued entries → all outputs 0 within the same cycle; after release, no s_read/s_write until new requests.
